mem_filter_master: RTL and testbench

- Memory initiator for the Memory_Management word memory; it drives the requester side (address, wdata, wboolean) and consumes rdata.
- On a start pulse it walks len words from src_base and applies the selected operation (pass / XOR key / NOT / ADD key) to each word.
- Each result is written to the matching word at dst_base.
- It is the sequenced hardware counterpart of the manual switch-driven XOR/NOT/ADD operations, and sits between the control logic and the memory.

---
 rtl/mem_filter_master.sv | 123 ++++++++++++
 tb/tb_mem_filter_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_filter_master.sv
// Sequenced word-memory initiator: reads len words from src_base, applies
// pass / XOR key / NOT / ADD key to each, and writes results to dst_base.
module mem_filter_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              wboolean,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_r;
  logic [DATA_W-1:0] key_r;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] res_p1;
  logic [ADDR_W-1:0] offs;

  // Reserved opcodes (1xx) fall through to pass.
  function automatic logic [DATA_W-1:0] apply_op(
    input logic [2:0]        o,
    input logic [DATA_W-1:0] k,
    input logic [DATA_W-1:0] x
  );
    case (o)
      3'b001:  apply_op = x ^ k;
      3'b010:  apply_op = ~x;
      3'b011:  apply_op = x + k;
      default: apply_op = x;
    endcase
  endfunction

  assign offs = ADDR_W'(idx) << 2;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : RD;
      RD:   state_nxt = WR;
      WR:   state_nxt = (idx == len_r - LEN_W'(1)) ? DONE : RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    address  = '0;
    wboolean = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RD: begin
        address = src_r + offs;
        busy    = 1'b1;
      end
      WR: begin
        address  = dst_r + offs;
        wboolean = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign wdata = res_p1;
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      res_p1 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          cnt <= '0;
        end
        // RD -> WR stage boundary: the filtered word is registered here
        RD: res_p1 <= apply_op(op_r, key_r, rdata);
        WR: begin
          idx <= idx + LEN_W'(1);
          cnt <= cnt + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Job parameters are captured once per accepted start and held for the job.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r  <= op;
      key_r <= key;
      src_r <= src_base;
      dst_r <= dst_base;
      len_r <= len;
    end
  end

endmodule

// File: tb/tb_mem_filter_master.sv
// Randomized scoreboard bench for mem_filter_master with a word-memory model.
module tb_mem_filter_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] key, src_base, dst_base;
  logic [15:0] len;
  logic [31:0] address, wdata, rdata;
  logic        wboolean, busy, done;
  logic [15:0] count;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        ld_en;
  logic [9:0]  ld_a;
  logic [31:0] ld_d;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  mem_filter_master #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .key(key),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .address(address), .wdata(wdata), .wboolean(wboolean), .rdata(rdata),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  assign rdata = mem[address[11:2]];

  always @(posedge clk) begin
    if (wboolean) mem[address[11:2]] <= wdata;
    else if (ld_en) mem[ld_a] <= ld_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] k,
                                         input logic [31:0] x);
    if (o == 3'd1) return x ^ k;
    if (o == 3'd2) return ~x;
    if (o == 3'd3) return x + k;
    return x;
  endfunction

  // Reference: word-by-word read-then-write over the model memory.
  task automatic model_job(input logic [2:0] o, input logic [31:0] k, input logic [31:0] s,
                           input logic [31:0] d, input int nwords);
    logic [31:0] ra, wa, r;
    wr_t e;
    for (int i = 0; i < nwords; i++) begin
      ra = s + 32'(i) * 4;
      wa = d + 32'(i) * 4;
      r  = ref_op(o, k, ref_mem[ra[11:2]]);
      ref_mem[wa[11:2]] = r;
      e.a = wa;
      e.d = r;
      exp_q.push_back(e);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a[11:2]; ld_d = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
    ref_mem[a[11:2]] = d;
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (wboolean) begin
        if (exp_q.size() == 0) chk("write_expected", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", address, e.a);
          chk("wr_data", wdata, e.d);
        end
      end
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] k, input logic [31:0] s,
                        input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    op = o; key = k; src_base = s; dst_base = d; len = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op = 3'($urandom); key = $urandom; src_base = $urandom; dst_base = $urandom;
    len = 16'($urandom);
  endtask

  task automatic run_job(input logic [2:0] o, input logic [31:0] k, input logic [31:0] s,
                         input logic [31:0] d, input logic [15:0] n, input bit dbl);
    int  strobes;
    bit  got;
    int  nn;
    nn = int'(n);
    model_job(o, k, s, d, nn);
    launch(o, k, s, d, n);
    strobes = 0;
    got = 1'b0;
    for (int c = 1; c <= 2 * nn + 8 && !got; c++) begin
      @(negedge clk);
      if (dbl) start = (c == 2);
      chk("busy", 32'(busy), 32'(c <= 2 * nn));
      if (wboolean) strobes++;
      if (done) begin
        got = 1'b1;
        chk("done_cycle", 32'(c), 32'(2 * nn + 1));
        chk("count_at_done", 32'(count), 32'(n));
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    chk("strobes", 32'(strobes), 32'(nn));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("count_held", 32'(count), 32'(n));
  endtask

  initial begin
    int mism;
    logic [31:0] s, d;
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    op = '0; key = '0; src_base = '0; dst_base = '0; len = '0;
    fork monitor(); join_none

    // Reset and idle
    @(posedge clk); @(negedge clk);
    chk("rst_address", address, 32'd0);
    chk("rst_wboolean", 32'(wboolean), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_address", address, 32'd0);
      chk("idle_wboolean", 32'(wboolean), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
    end

    for (int i = 0; i < 1024; i++) preload(32'(i) << 2, $urandom);

    // XOR job
    preload(32'h100, 32'h12345678);
    preload(32'h104, 32'h0000FFFF);
    run_job(3'b001, 32'hFFFF0000, 32'h100, 32'h200, 16'd2, 1'b0);
    chk("xor_w0", mem[10'h080], 32'hEDCB5678);
    chk("xor_w1", mem[10'h081], 32'hFFFFFFFF);

    // ADD wrap
    preload(32'h010, 32'hFFFFFFFF);
    run_job(3'b011, 32'd1, 32'h010, 32'h020, 16'd1, 1'b0);
    chk("add_wrap", mem[10'h008], 32'h00000000);
    chk("add_src_kept", mem[10'h004], 32'hFFFFFFFF);

    // In-place NOT
    preload(32'h004, 32'h00000000);
    preload(32'h008, 32'hA5A5A5A5);
    preload(32'h00C, 32'hFFFFFFFF);
    run_job(3'b010, 32'h0, 32'h004, 32'h004, 16'd3, 1'b0);
    chk("not_w0", mem[10'h001], 32'hFFFFFFFF);
    chk("not_w1", mem[10'h002], 32'h5A5A5A5A);
    chk("not_w2", mem[10'h003], 32'h00000000);

    // len=0, then a second start during a running job
    run_job(3'b001, 32'h1234, 32'h300, 32'h340, 16'd0, 1'b0);
    run_job(3'b001, 32'h5555AAAA, 32'h380, 32'h3C0, 16'd2, 1'b1);

    // Address wrap past 2^32 and reserved opcode
    run_job(3'b110, 32'hDEADBEEF, 32'hFFFFFFF8, 32'h00000800, 16'd4, 1'b0);

    // Randomized jobs, some overlapping
    for (int j = 0; j < 25; j++) begin
      s = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) d = s + (32'($urandom_range(0, 3)) << 2);
      else d = 32'($urandom_range(0, 1023)) << 2;
      run_job(3'($urandom_range(0, 7)), $urandom, s, d, 16'($urandom_range(0, 8)),
              bit'($urandom_range(0, 1)));
    end

    // Reset during the WR cycle of word 1 of a 4-word job
    model_job(3'b001, 32'hF0F0F0F0, 32'h600, 32'h700, 2);
    launch(3'b001, 32'hF0F0F0F0, 32'h600, 32'h700, 16'd4);
    repeat (4) @(negedge clk);
    chk("midrst_wr_high", 32'(wboolean), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_wboolean", 32'(wboolean), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_address", address, 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    repeat (10) @(negedge clk);
    chk("midrst_w2_untouched", mem[10'h1C2], ref_mem[10'h1C2]);
    chk("midrst_w3_untouched", mem[10'h1C3], ref_mem[10'h1C3]);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
